mips_bus_arbiter: RTL and testbench

//  Shares one Avalon memory-mapped master port between two requesters:
//  - instruction-fetch port (read-only)
//  - data port (read/write)

---
 rtl/mips_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Shares one Avalon-MM master port between the instruction-fetch port (i_*)
//   and the data port (d_*) of a split-port MIPS core.
//
//   Arbitration is registered and round-robin. A granted transfer owns the bus
//   until it completes. A sticky flag records a transfer that stalls too long.
//
//   Ports:
//     clk, reset       clock; synchronous active-high reset
//     i_*              instruction read port (read-only slave side)
//     d_*              data read/write port (slave side)
//     address/read/write/byteenable/writedata/waitrequest/readdata
//                      Avalon master towards memory
//     bus_timeout      sticky; MAX_WAIT consecutive stalled cycles were seen
//                      (MAX_WAIT = 0 disables the check)
module mips_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                bus_timeout
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0] CNT_MAX = (CNT_W + 1)'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_timeout_q, bus_timeout_d;

  logic             d_req;
  logic             stall;
  logic [CNT_W:0]   cnt_inc;

  assign d_req       = d_read | d_write;
  assign cnt_inc     = {1'b0, wait_cnt_q} + CNT_ONE;
  assign bus_timeout = bus_timeout_q;

  // Read data is a plain passthrough; requesters only sample it when their
  // waitrequest is low.
  assign i_readdata = readdata;
  assign d_readdata = readdata;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    byteenable    = '0;
    writedata     = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    stall         = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time gets the bus.
        if (i_read && (!d_req || last_grant_q)) state_d = GNT_I;
        else if (d_req)                         state_d = GNT_D;
      end
      GNT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = '1;
        i_waitrequest = waitrequest;
        if (!i_read) begin
          state_d = IDLE;  // requester abandoned the transfer
        end else if (!waitrequest) begin
          last_grant_d = 1'b0;
          state_d      = d_req ? GNT_D : IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      GNT_D: begin
        address       = d_address;
        read          = d_read & ~d_write;  // write wins if both are raised
        write         = d_write;
        byteenable    = d_byteenable;
        writedata     = d_writedata;
        d_waitrequest = waitrequest;
        if (!d_req) begin
          state_d = IDLE;
        end else if (!waitrequest) begin
          last_grant_d = 1'b1;
          state_d      = i_read ? GNT_I : IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall counter: consecutive stalled granted cycles, saturating at MAX_WAIT.
  // The flag is set by the stalled cycle that brings the count to MAX_WAIT.
  always_comb begin
    wait_cnt_d    = '0;
    bus_timeout_d = bus_timeout_q;
    if (MAX_WAIT != 0 && stall) begin
      wait_cnt_d = (cnt_inc > CNT_MAX) ? wait_cnt_q : cnt_inc[CNT_W-1:0];
      if (cnt_inc >= CNT_MAX) bus_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      wait_cnt_q    <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write, waitrequest;
  logic [31:0] i_address, d_address, d_writedata, readdata;
  logic [3:0]  d_byteenable;
  logic        i_waitrequest, d_waitrequest, read, write, bus_timeout;
  logic [31:0] i_readdata, d_readdata, address, writedata;
  logic [3:0]  byteenable;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_byteenable(d_byteenable), .d_writedata(d_writedata),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata),
    .bus_timeout(bus_timeout)
  );

  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic        wr;
    logic [31:0] rd;
    logic [72:0] exp;
    logic        ci, cd;  // check i_readdata / d_readdata against rd
  } vec_t;

  function automatic logic [72:0] ex(input logic rd_, wr_, input logic [31:0] a,
                                     input logic [3:0] be, input logic [31:0] wd,
                                     input logic iw, dw, to);
    return {rd_, wr_, a, be, wd, iw, dw, to};
  endfunction

  function automatic vec_t v(input logic rst, ir, input logic [31:0] ia,
                             input logic dr, dw, input logic [31:0] da,
                             input logic [3:0] dbe, input logic [31:0] dwd,
                             input logic wr, input logic [31:0] rd,
                             input logic [72:0] e, input logic ci, cd);
    vec_t r;
    r.rst = rst; r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da;
    r.dbe = dbe; r.dwd = dwd; r.wr = wr; r.rd = rd; r.exp = e; r.ci = ci; r.cd = cd;
    return r;
  endfunction

  function automatic logic [72:0] obs();
    return {read, write, address, byteenable, writedata, i_waitrequest, d_waitrequest, bus_timeout};
  endfunction

  task automatic check(input string nm, input logic [72:0] got, input logic [72:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", nm, got, want);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, then let them settle.
  task automatic apply(input vec_t r);
    reset = r.rst; i_read = r.ir; i_address = r.ia;
    d_read = r.dr; d_write = r.dw; d_address = r.da;
    d_byteenable = r.dbe; d_writedata = r.dwd;
    waitrequest = r.wr; readdata = r.rd;
    #2;
  endtask

  vec_t        tbl[$];
  logic [72:0] idl;
  vec_t        h;

  initial begin
    idl = ex(0, 0, 0, 0, 0, 1, 1, 0);
    // 1: single instruction fetch, zero wait
    tbl.push_back(v(1, 0, 0,     0, 0, 0, 0, 0, 0, 0,           idl, 0, 0));
    tbl.push_back(v(0, 1, 'h10,  0, 0, 0, 0, 0, 0, 'h24020005,  idl, 0, 0));
    tbl.push_back(v(0, 1, 'h10,  0, 0, 0, 0, 0, 0, 'h24020005,  ex(1, 0, 'h10, 'hf, 0, 0, 1, 0), 1, 0));
    tbl.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,           idl, 0, 0));
    // 2: simultaneous I read and D write after reset: I first, D back-to-back
    tbl.push_back(v(1, 0, 0,     0, 0, 0, 0, 0, 0, 0,           idl, 0, 0));
    tbl.push_back(v(0, 1, 'h10,  0, 1, 'h100, 'h3, 'hdeadbeef, 0, 0, idl, 0, 0));
    tbl.push_back(v(0, 1, 'h10,  0, 1, 'h100, 'h3, 'hdeadbeef, 0, 0, ex(1, 0, 'h10, 'hf, 0, 0, 1, 0), 0, 0));
    tbl.push_back(v(0, 0, 0,     0, 1, 'h100, 'h3, 'hdeadbeef, 0, 0, ex(0, 1, 'h100, 'h3, 'hdeadbeef, 1, 0, 0), 0, 0));
    tbl.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,           idl, 0, 0));
    // 3: both requesting continuously: I,D,I,D,I,D
    tbl.push_back(v(0, 1, 'h20,  1, 0, 'h300, 'hf, 0, 0, 'ha5,  idl, 0, 0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(v(0, 1, 'h20, 1, 0, 'h300, 'hf, 0, 0, 'ha5, ex(1, 0, 'h20, 'hf, 0, 0, 1, 0), 1, 0));
      tbl.push_back(v(0, 1, 'h20, 1, 0, 'h300, 'hf, 0, 0, 'ha5, ex(1, 0, 'h300, 'hf, 0, 1, 0, 0), 0, 1));
    end
    tbl.push_back(v(0, 1, 'h20,  1, 0, 'h300, 'hf, 0, 0, 'ha5,  ex(1, 0, 'h20, 'hf, 0, 0, 1, 0), 1, 0));
    tbl.push_back(v(0, 0, 0,     1, 0, 'h300, 'hf, 0, 0, 'ha5,  ex(1, 0, 'h300, 'hf, 0, 1, 0, 0), 0, 1));
    tbl.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,           idl, 0, 0));
    // 4: data read with 3 wait cycles while an I read queues behind it
    tbl.push_back(v(0, 0, 0,     1, 0, 'h200, 'hf, 0, 1, 0,     idl, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(0, 1, 'h40, 1, 0, 'h200, 'hf, 0, 1, 0,    ex(1, 0, 'h200, 'hf, 0, 1, 1, 0), 0, 0));
    tbl.push_back(v(0, 1, 'h40,  1, 0, 'h200, 'hf, 0, 0, 'h12345678, ex(1, 0, 'h200, 'hf, 0, 1, 0, 0), 0, 1));
    tbl.push_back(v(0, 1, 'h40,  0, 0, 0, 0, 0, 0, 'h0badf00d,  ex(1, 0, 'h40, 'hf, 0, 0, 1, 0), 1, 0));
    tbl.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,           idl, 0, 0));
    // 6: reset during a stalled instruction grant
    tbl.push_back(v(0, 1, 'h50,  0, 0, 0, 0, 0, 1, 0,           idl, 0, 0));
    tbl.push_back(v(0, 1, 'h50,  0, 0, 0, 0, 0, 1, 0,           ex(1, 0, 'h50, 'hf, 0, 1, 1, 0), 0, 0));
    tbl.push_back(v(1, 1, 'h50,  0, 0, 0, 0, 0, 1, 0,           ex(1, 0, 'h50, 'hf, 0, 1, 1, 0), 0, 0));
    tbl.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,           idl, 0, 0));

    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, idl, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      apply(tbl[i]);
      check($sformatf("vec%0d", i), obs(), tbl[i].exp);
      if (tbl[i].ci) check($sformatf("vec%0d_irdata", i), 73'(i_readdata), 73'(tbl[i].rd));
      if (tbl[i].cd) check($sformatf("vec%0d_drdata", i), 73'(d_readdata), 73'(tbl[i].rd));
      @(negedge clk);
    end

    // Requester drops its strobe mid-transfer: strobe falls at once, IDLE next.
    h = v(0, 1, 'h60, 0, 0, 0, 0, 0, 1, 0, idl, 0, 0);
    apply(h); @(negedge clk);
    apply(h); check("drop_granted", 73'(read), 73'(1)); @(negedge clk);
    h.ir = 1'b0;
    apply(h); check("drop_read", 73'(read), 73'(0)); @(negedge clk);
    h.wr = 1'b0;
    apply(h); check("drop_idle", 73'({byteenable, i_waitrequest}), 73'(5'b0000_1)); @(negedge clk);

    // Timeout: MAX_WAIT=4, data write stuck in wait.
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, idl, 0, 0)); @(negedge clk);
    h = v(0, 0, 0, 0, 1, 'h80, 'hf, 'h1, 1, 0, idl, 0, 0);
    apply(h); @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      apply(h); check($sformatf("stall%0d", k), 73'({write, bus_timeout}), 73'(2'b10)); @(negedge clk);
    end
    apply(h); check("timeout_set", 73'({write, bus_timeout}), 73'(2'b11)); @(negedge clk);
    h.wr = 1'b0;
    apply(h); check("timeout_complete", 73'({d_waitrequest, bus_timeout}), 73'(2'b01)); @(negedge clk);
    h.dw = 1'b0;
    apply(h); check("timeout_sticky", 73'(bus_timeout), 73'(1)); @(negedge clk);

    // Reset while stalled in GNT_I clears the flag and drops the strobe.
    h = v(0, 1, 'h70, 0, 0, 0, 0, 0, 1, 0, idl, 0, 0);
    apply(h); @(negedge clk);
    apply(h); check("rst_stall_pre", 73'({read, bus_timeout}), 73'(2'b11)); @(negedge clk);
    h.rst = 1'b1;
    apply(h); @(negedge clk);
    h.rst = 1'b0;
    apply(h); check("rst_stall_post", 73'({read, byteenable, bus_timeout}), 73'(6'b0)); @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
